fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Front-end fetch stage (IF1/IF2) that generates fetch PCs, issues aligned 64-bit requests to the ICache and presents up to two PC/IR pairs per cycle to the downstream IF2_ID1 instruction buffer. It owns the PC register, the branch-redirect path and the IF1→IF2 pipeline register. It throttles itself on ICache miss and on the buffer's full indication.

## Interface
- RESET_PC, 32'h1C00_0000, fetch PC loaded on reset.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush_BR  in  1  branch redirect; highest priority.
- br_target  in  32  redirect PC, word-aligned; used when flush_BR=1.
- buf_full  in  1  buffer full indication from IF2_ID1 (its o_is_full).
- stall_ICache  in  1  ICache miss/busy; data for the IF2 pair not available this cycle.
- icache_rdata  in  64  aligned doubleword for the IF2 pair; [31:0] = addr+0, [63:32] = addr+4.
- icache_req  out  1  request valid.
- icache_addr  out  32  request address = pc with [2:0] cleared.
- o_PC1, o_IR1, o_PC2, o_IR2  out  32 each  pair to buffer (i_PC1…i_IR2).
- o_is_valid  out  2  11 both pairs, 10 first only, 00 none.

## Operation
- Registers: pc[31:0], f2_pc[31:0], f2_mask[1:0], f2_v, state {IDLE, RUN, MISS, BLOCK}.
- Slot mask: pc[2]=0 → 11 (pc, pc+4); pc[2]=1 → 10 (pc only). next_pc = {pc[31:3],3'b0} + 8, modulo 2^32 (wraps at 32'hFFFF_FFF8 → 0).
- advance = (state==RUN) & ~stall_ICache & ~buf_full & ~flush_BR. On advance: pc←next_pc, f2_pc←pc, f2_mask←slot mask, f2_v←1.
- IF2 retire: f2_v & ~stall_ICache and no advance → f2_v←0. While stall_ICache, f2 is held unchanged.
- Output data: o_PC1=f2_pc; o_IR1 = f2_pc[2] ? rdata[63:32] : rdata[31:0]; o_PC2=f2_pc+4; o_IR2=rdata[63:32].
- o_is_valid = (f2_v & ~stall_ICache) ? f2_mask : 00. The buffer additionally masks with stall_ICache.
- icache_req = (state==RUN | state==MISS) & ~buf_full. icache_addr = {pc[31:3],3'b0}.
- FSM, priority flush_BR > stall_ICache > buf_full:
  - IDLE→RUN unconditionally.
  - RUN→MISS on stall_ICache; RUN→BLOCK on buf_full.
  - MISS→RUN when ~stall_ICache, or →BLOCK if buf_full.
  - BLOCK→RUN when ~buf_full.
  - Any state→RUN on flush_BR, except during rst.
- flush_BR: pc←br_target, f2_v←0, o_is_valid=00 in the flush cycle, regardless of stall_ICache/buf_full. An in-flight miss is abandoned; the ICache sees the new icache_addr next cycle.
- buf_full: no new request; a pending f2 pair still retires (the buffer's 6-entry slack absorbs it).

## Timing
- Reset (rst high at edge): pc=RESET_PC, f2_v=0, f2_pc=0, f2_mask=00, state=IDLE. Outputs: icache_req=0, o_is_valid=00, o_PC/IR=0 (icache_rdata undefined is masked).
- Cycle after reset release: IDLE, no request. Next cycle: first request at RESET_PC.
- Latency: request accepted at edge N → pair presented on o_* during cycle N+1 if stall_ICache=0 → written into buffer at edge N+2.
- Steady state: one aligned fetch per cycle, 2 instr/cycle from aligned PCs.
- Redirect: flush_BR at edge N → first request at br_target in cycle N+1 → its pair valid in cycle N+2 earliest.
- rst asserted mid-miss or mid-flush overrides everything at that edge.

## Configuration
- FETCH_SINGLE_ISSUE_EN defined: slot mask is always 10; next_pc = pc+4; o_is_valid never 11; o_PC2/o_IR2 driven 0.
- Undefined: dual-slot behaviour as above.

## Test plan
- Reset release, no stalls: icache_addr 1C00_0000, 1C00_0008, 1C00_0010…; o_is_valid=11 from cycle 3 with o_PC1=1C00_0000, o_PC2=1C00_0004.
- flush_BR with br_target=1C00_0104: next pair o_PC1=1C00_0104, o_is_valid=10, o_IR1=rdata[63:32]; following pair 1C00_0108/010C, o_is_valid=11.
- stall_ICache high 5 cycles with f2 pending: o_is_valid=00, pc and f2_pc frozen, icache_addr constant; pair emitted the cycle stall drops, no duplicate or loss.
- buf_full high 3 cycles: icache_req=0, pending pair still emitted once, zero PCs skipped on release.
- flush_BR coincident with stall_ICache and buf_full: state→RUN, f2_v=0, pc=br_target; the old pair is never emitted.
- Wrap: pc=FFFF_FFF8 → next icache_addr 0000_0000. With FETCH_SINGLE_ISSUE_EN: PCs step by 4 and o_is_valid stays 10.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen
// Front-end fetch stage (IF1/IF2). Owns the fetch PC, the branch-redirect
// path and the IF1->IF2 register. Each RUN cycle it issues one aligned 64-bit
// ICache request. The doubleword that comes back is split into up to two
// PC/IR pairs for the IF2_ID1 instruction buffer.
//
// Build option: define FETCH_SINGLE_ISSUE_EN to fetch one instruction per
// cycle. In that mode the slot mask is always 10, the PC steps by 4 and
// o_PC2/o_IR2 are driven 0. When it is undefined the stage is dual-slot.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_BR        branch redirect (highest priority), br_target = new PC
//   buf_full        instruction buffer full, suppresses new requests
//   stall_ICache    ICache miss/busy, IF2 data not available this cycle
//   icache_rdata    aligned doubleword, [31:0]=addr+0, [63:32]=addr+4
//   icache_req      request valid
//   icache_addr     request address (pc with [2:0] cleared)
//   o_PC1/o_IR1     first pair to the buffer
//   o_PC2/o_IR2     second pair to the buffer
//   o_is_valid      11 both pairs, 10 first only, 00 none
`timescale 1ns/1ps

module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_BR,
  input  logic [31:0] br_target,
  input  logic        buf_full,
  input  logic        stall_ICache,
  input  logic [63:0] icache_rdata,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  output logic [31:0] o_PC1,
  output logic [31:0] o_IR1,
  output logic [31:0] o_PC2,
  output logic [31:0] o_IR2,
  output logic [1:0]  o_is_valid
);

  typedef enum logic [1:0] {IDLE, RUN, MISS, BLOCK} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] f2_pc;
  logic [1:0]  f2_mask;
  logic        f2_v;

  logic [31:0] pc_aligned;
  logic [31:0] next_pc;
  logic [1:0]  slot_mask;
  logic        advance;
  logic        f2_present;

  assign pc_aligned = {pc[31:3], 3'b000};

`ifdef FETCH_SINGLE_ISSUE_EN
  assign next_pc   = pc + 32'd4;
  assign slot_mask = 2'b10;
`else
  // The pc+4 slot is only in the same doubleword when pc sits in its lower word.
  assign next_pc   = pc_aligned + 32'd8;
  assign slot_mask = pc[2] ? 2'b10 : 2'b11;
`endif

  assign advance = (state == RUN) & ~stall_ICache & ~buf_full & ~flush_BR;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state, priority flush_BR > stall_ICache > buf_full
  always_comb begin
    state_nxt = state;
    if (flush_BR) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:  state_nxt = RUN;
        RUN: begin
          if (stall_ICache)  state_nxt = MISS;
          else if (buf_full) state_nxt = BLOCK;
        end
        MISS: begin
          if (!stall_ICache) state_nxt = buf_full ? BLOCK : RUN;
        end
        BLOCK: begin
          if (!buf_full)     state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // IF1 -> IF2 boundary: PC register and IF2 pair register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      f2_pc   <= '0;
      f2_mask <= 2'b00;
      f2_v    <= 1'b0;
    end else if (flush_BR) begin
      // The old pair and any in-flight miss are dropped here.
      pc      <= br_target;
      f2_v    <= 1'b0;
    end else if (advance) begin
      pc      <= next_pc;
      f2_pc   <= pc;
      f2_mask <= slot_mask;
      f2_v    <= 1'b1;
    end else if (f2_v && !stall_ICache) begin
      // The pair was presented this cycle and the buffer takes it.
      f2_v    <= 1'b0;
    end
  end

  assign icache_req  = ((state == RUN) | (state == MISS)) & ~buf_full;
  assign icache_addr = pc_aligned;

  // IF2 outputs. Data is gated by f2_v so undefined rdata never leaks out.
  assign f2_present = f2_v & ~stall_ICache & ~flush_BR;

  always_comb begin
    o_is_valid = f2_present ? f2_mask : 2'b00;
    o_PC1      = '0;
    o_IR1      = '0;
    o_PC2      = '0;
    o_IR2      = '0;
    if (f2_v) begin
      o_PC1 = f2_pc;
      o_IR1 = f2_pc[2] ? icache_rdata[63:32] : icache_rdata[31:0];
`ifndef FETCH_SINGLE_ISSUE_EN
      o_PC2 = f2_pc + 32'd4;
      o_IR2 = icache_rdata[63:32];
`endif
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
`timescale 1ns/1ps

module tb_fetch_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        rst, flush_BR, buf_full, stall_ICache;
  logic [31:0] br_target;
  logic [63:0] icache_rdata;
  logic        icache_req;
  logic [31:0] icache_addr, o_PC1, o_IR1, o_PC2, o_IR2;
  logic [1:0]  o_is_valid;

  always #5 clk = ~clk;

  fetch_pc_gen #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .flush_BR(flush_BR), .br_target(br_target),
    .buf_full(buf_full), .stall_ICache(stall_ICache), .icache_rdata(icache_rdata),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .o_PC1(o_PC1), .o_IR1(o_IR1), .o_PC2(o_PC2), .o_IR2(o_IR2),
    .o_is_valid(o_is_valid)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: the fetcher either may fetch this cycle or is waiting
  // out the first cycle after reset, a miss, or a full buffer.
  logic        m_init = 1'b0;
  logic [31:0] m_pc;
  logic        m_pv;
  logic [31:0] m_ppc;
  logic [1:0]  m_pmask;
  logic        m_idle, m_wmiss, m_wfull;

  function automatic logic m_go();
    return m_init && !m_idle && !m_wmiss && !m_wfull;
  endfunction

  function automatic logic [1:0] m_slots(input logic [31:0] p);
`ifdef FETCH_SINGLE_ISSUE_EN
    return 2'b10;
`else
    return (p % 8 == 0) ? 2'b11 : 2'b10;
`endif
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] p);
`ifdef FETCH_SINGLE_ISSUE_EN
    return p + 4;
`else
    return (p & 32'hFFFF_FFF8) + 8;
`endif
  endfunction

  task automatic model_check(input string tag);
    logic [31:0] hi, lo, e_pc2, e_ir2;
    if (!m_init) return;
    hi = icache_rdata[63:32];
    lo = icache_rdata[31:0];
    e_pc2 = 0;
    e_ir2 = 0;
`ifndef FETCH_SINGLE_ISSUE_EN
    if (m_pv) begin
      e_pc2 = m_ppc + 4;
      e_ir2 = hi;
    end
`endif
    chk({tag, " valid"}, 64'(o_is_valid),
        64'((m_pv && !stall_ICache && !flush_BR) ? m_pmask : 2'b00));
    chk({tag, " req"},  64'(icache_req), 64'((m_go() || m_wmiss) && !buf_full));
    chk({tag, " addr"}, 64'(icache_addr), 64'(m_pc & 32'hFFFF_FFF8));
    chk({tag, " pc1"},  64'(o_PC1), 64'(m_pv ? m_ppc : 32'd0));
    chk({tag, " ir1"},  64'(o_IR1), 64'(m_pv ? ((m_ppc % 8 == 4) ? hi : lo) : 32'd0));
    chk({tag, " pc2"},  64'(o_PC2), 64'(e_pc2));
    chk({tag, " ir2"},  64'(o_IR2), 64'(e_ir2));
  endtask

  task automatic model_tick();
    logic go;
    go = m_go();
    if (rst) begin
      m_init = 1; m_pc = RESET_PC; m_pv = 0; m_ppc = 0; m_pmask = 0;
      m_idle = 1; m_wmiss = 0; m_wfull = 0;
    end else if (m_init) begin
      if (flush_BR) begin
        m_pc = br_target; m_pv = 0; m_idle = 0; m_wmiss = 0; m_wfull = 0;
      end else begin
        if (go && !stall_ICache && !buf_full) begin
          m_ppc = m_pc; m_pmask = m_slots(m_pc); m_pv = 1; m_pc = m_next(m_pc);
        end else if (m_pv && !stall_ICache) begin
          m_pv = 0;
        end
        if (m_idle) m_idle = 0;
        else if (go) begin
          if (stall_ICache)  m_wmiss = 1;
          else if (buf_full) m_wfull = 1;
        end else if (m_wmiss) begin
          if (!stall_ICache) begin m_wmiss = 0; m_wfull = buf_full; end
        end else if (m_wfull) begin
          if (!buf_full) m_wfull = 0;
        end
      end
    end
  endtask

  typedef struct {
    logic        rst, flush, full, stall;
    logic [31:0] br;
    logic [63:0] rdata;
    logic        chk, req;
    logic [31:0] addr;
    logic [1:0]  vld;
    logic [31:0] pc1, pc2, ir1;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic [31:0] b,
                              input logic fu, input logic st, input logic [63:0] rd,
                              input logic c, input logic rq, input logic [31:0] ad,
                              input logic [1:0] vl, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] i1);
    vec_t v;
    v.rst = r; v.flush = f; v.br = b; v.full = fu; v.stall = st; v.rdata = rd;
    v.chk = c; v.req = rq; v.addr = ad; v.vld = vl; v.pc1 = p1; v.pc2 = p2; v.ir1 = i1;
    return v;
  endfunction

  task automatic apply(input logic r, input logic f, input logic [31:0] b,
                       input logic fu, input logic st, input logic [63:0] rd);
    rst = r; flush_BR = f; br_target = b; buf_full = fu; stall_ICache = st;
    icache_rdata = rd;
  endtask

  vec_t tbl[$];

  initial begin
    apply(1, 0, 0, 0, 0, 0);

`ifndef FETCH_SINGLE_ISSUE_EN
    //                r  f  br            fu st rdata                    c  rq addr          vld    pc1           pc2           ir1
    tbl.push_back(mk(1, 0, 0,            0, 0, 64'h0,                   0, 0, 0,            2'b00, 0,            0,            0));
    tbl.push_back(mk(1, 0, 0,            0, 0, 64'h0,                   1, 0, 32'h1C000000, 2'b00, 0,            0,            0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h0,                   1, 0, 32'h1C000000, 2'b00, 0,            0,            0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h0,                   1, 1, 32'h1C000000, 2'b00, 0,            0,            0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h11111111_22222222,   1, 1, 32'h1C000008, 2'b11, 32'h1C000000, 32'h1C000004, 32'h22222222));
    tbl.push_back(mk(0, 1, 32'h1C000104, 0, 0, 64'h0,                   1, 1, 32'h1C000010, 2'b00, 32'h1C000008, 32'h1C00000C, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h0,                   1, 1, 32'h1C000100, 2'b00, 0,            0,            0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h33333333_44444444,   1, 1, 32'h1C000108, 2'b10, 32'h1C000104, 32'h1C000108, 32'h33333333));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0,          0, 1, 64'h0,                   1, 1, 32'h1C000110, 2'b00, 32'h1C000108, 32'h1C00010C, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h55555555_66666666,   1, 1, 32'h1C000110, 2'b11, 32'h1C000108, 32'h1C00010C, 32'h66666666));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h0,                   1, 1, 32'h1C000110, 2'b00, 0,            0,            0));
    tbl.push_back(mk(0, 0, 0,            1, 0, 64'h0,                   1, 0, 32'h1C000118, 2'b11, 32'h1C000110, 32'h1C000114, 0));
    tbl.push_back(mk(0, 0, 0,            1, 0, 64'h0,                   1, 0, 32'h1C000118, 2'b00, 0,            0,            0));
    tbl.push_back(mk(0, 0, 0,            1, 0, 64'h0,                   1, 0, 32'h1C000118, 2'b00, 0,            0,            0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h0,                   1, 0, 32'h1C000118, 2'b00, 0,            0,            0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h0,                   1, 1, 32'h1C000118, 2'b00, 0,            0,            0));
    tbl.push_back(mk(0, 1, 32'h1C000200, 1, 1, 64'h0,                   1, 0, 32'h1C000120, 2'b00, 32'h1C000118, 32'h1C00011C, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h0,                   1, 1, 32'h1C000200, 2'b00, 0,            0,            0));
    tbl.push_back(mk(0, 1, 32'hFFFFFFF8, 0, 0, 64'h0,                   1, 1, 32'h1C000208, 2'b00, 32'h1C000200, 32'h1C000204, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h0,                   1, 1, 32'hFFFFFFF8, 2'b00, 0,            0,            0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h0,                   1, 1, 32'h00000000, 2'b11, 32'hFFFFFFF8, 32'hFFFFFFFC, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0, 64'h0,                   1, 1, 32'h00000008, 2'b11, 32'h00000000, 32'h00000004, 0));
`else
    tbl.push_back(mk(1, 0, 0, 0, 0, 64'h0, 0, 0, 0, 2'b00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 64'h0, 1, 0, 32'h1C000000, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 64'h0, 1, 0, 32'h1C000000, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 64'h0, 1, 1, 32'h1C000000, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 64'h0, 1, 1, 32'h1C000000, 2'b10, 32'h1C000000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 64'h0, 1, 1, 32'h1C000008, 2'b10, 32'h1C000004, 0, 0));
`endif

    foreach (tbl[k]) begin
      @(negedge clk);
      apply(tbl[k].rst, tbl[k].flush, tbl[k].br, tbl[k].full, tbl[k].stall, tbl[k].rdata);
      #1;
      if (tbl[k].chk) begin
        chk($sformatf("row%0d valid", k), 64'(o_is_valid), 64'(tbl[k].vld));
        chk($sformatf("row%0d req", k),   64'(icache_req),  64'(tbl[k].req));
        chk($sformatf("row%0d addr", k),  64'(icache_addr), 64'(tbl[k].addr));
        chk($sformatf("row%0d pc1", k),   64'(o_PC1),       64'(tbl[k].pc1));
        chk($sformatf("row%0d pc2", k),   64'(o_PC2),       64'(tbl[k].pc2));
        chk($sformatf("row%0d ir1", k),   64'(o_IR1),       64'(tbl[k].ir1));
      end
      model_check($sformatf("row%0d model", k));
      @(posedge clk);
      model_tick();
    end

    for (int c = 0; c < 3000; c++) begin
      logic [31:0] b;
      @(negedge clk);
      b = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFE0 | ($urandom & 32'h1C);
      apply($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 5, b,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20,
            {$urandom, $urandom});
      #1;
      model_check($sformatf("rand%0d", c));
      @(posedge clk);
      model_tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
